maxpool2x2: RTL

//  Streaming 2x2/stride-2 max-pool stage directly downstream of the layer-0 conv MAC array.

---
 rtl/pool_pkg.sv | 31 +++
 rtl/maxpool2x2_if.sv | 25 ++
 rtl/pool_lane_max.sv | 22 ++
 rtl/maxpool2x2.sv | 123 ++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// Shared types, constants and the per-lane signed max for the 2x2 max-pool stage.
package pool_pkg;

    localparam int unsigned LANES      = 16;
    localparam int unsigned LANE_W     = 8;
    localparam int unsigned VEC_W      = LANES * LANE_W;
    localparam int unsigned WIDTH_DEF  = 320;
    localparam int unsigned HEIGHT_DEF = 320;
    localparam int unsigned CNT_W      = 12;

    typedef logic [VEC_W-1:0]         vec_t;
    typedef logic signed [LANE_W-1:0] lane_t;
    typedef logic [CNT_W-1:0]         cnt_t;

    // Position of an input pixel inside its 2x2 tile, encoded as {row[0], col[0]}.
    typedef enum logic [1:0] {
        PH_TOP_L = 2'b00,
        PH_TOP_R = 2'b01,
        PH_BOT_L = 2'b10,
        PH_BOT_R = 2'b11
    } tile_phase_e;

    function automatic lane_t lane_smax(input lane_t a, input lane_t b);
        return (a > b) ? a : b;
    endfunction

    function automatic lane_t lane_relu(input lane_t a);
        return a[LANE_W-1] ? lane_t'(0) : a;
    endfunction

endpackage

// File: rtl/maxpool2x2_if.sv
// Pixel-stream bus into the max-pool stage and pooled-tile bus out of it.
interface maxpool2x2_if import pool_pkg::*; ();

    logic clr_i;
    logic vld_i;
    vec_t din;
    logic vld_o;
    vec_t dout;
    cnt_t row_o;
    cnt_t col_o;
    logic frame_done;

    // Upstream conv array / test driver side.
    modport master (
        output clr_i, vld_i, din,
        input  vld_o, dout, row_o, col_o, frame_done
    );

    // Max-pool stage side.
    modport slave (
        input  clr_i, vld_i, din,
        output vld_o, dout, row_o, col_o, frame_done
    );

endinterface

// File: rtl/pool_lane_max.sv
// Combinational lane-wise signed max of two packed lane vectors.
// With MAXPOOL_RELU_EN defined, each input lane is clamped to >= 0 first (fused ReLU).
module pool_lane_max import pool_pkg::*; (
    input  vec_t a,
    input  vec_t b,
    output vec_t y
);

    // Independent signed compare per lane.
    always_comb begin
        y = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
`ifdef MAXPOOL_RELU_EN
            y[k*LANE_W +: LANE_W] = lane_smax(lane_relu(a[k*LANE_W +: LANE_W]),
                                              lane_relu(b[k*LANE_W +: LANE_W]));
`else
            y[k*LANE_W +: LANE_W] = lane_smax(a[k*LANE_W +: LANE_W], b[k*LANE_W +: LANE_W]);
`endif
        end
    end

endmodule

// File: rtl/maxpool2x2.sv
// Streaming 2x2 / stride-2 max-pool over a raster-order 16-lane pixel stream.
// Optional fused ReLU is selected by MAXPOOL_RELU_EN (applied inside pool_lane_max).
module maxpool2x2 import pool_pkg::*; #(
    parameter int unsigned WIDTH  = WIDTH_DEF,
    parameter int unsigned HEIGHT = HEIGHT_DEF
) (
    input  logic         clk,
    input  logic         rstn,
    maxpool2x2_if.slave  bus
);

    localparam int unsigned LB_DEPTH = WIDTH / 2;
    localparam int unsigned LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
    localparam cnt_t        COL_LAST = cnt_t'(WIDTH - 1);
    localparam cnt_t        ROW_LAST = cnt_t'(HEIGHT - 1);

    if ((WIDTH % 2) != 0 || WIDTH < 2) begin : g_width_chk
        $error("maxpool2x2: WIDTH must be even and at least 2");
    end
    if ((HEIGHT % 2) != 0 || HEIGHT < 2) begin : g_height_chk
        $error("maxpool2x2: HEIGHT must be even and at least 2");
    end

    cnt_t        col_q, col_d;
    cnt_t        row_q, row_d;
    vec_t        hold_q, hold_d;
    vec_t        dout_q, dout_d;
    cnt_t        row_o_q, row_o_d;
    cnt_t        col_o_q, col_o_d;
    logic        vld_o_q, vld_o_d;
    logic        fd_q, fd_d;

    vec_t        linebuf_q [LB_DEPTH];
    logic        lb_we;
    logic [LB_AW-1:0] lb_idx;
    vec_t        lb_rdata;
    vec_t        hmax;
    vec_t        vmax;
    tile_phase_e phase;

    assign lb_idx   = col_q[LB_AW:1];
    assign lb_rdata = linebuf_q[lb_idx];

    pool_lane_max u_hmax (.a(hold_q),   .b(bus.din), .y(hmax));
    pool_lane_max u_vmax (.a(lb_rdata), .b(hmax),    .y(vmax));

    // Raster counters, horizontal hold, line-buffer write strobe and tile output.
    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        hold_d  = hold_q;
        dout_d  = dout_q;
        row_o_d = row_o_q;
        col_o_d = col_o_q;
        vld_o_d = 1'b0;
        fd_d    = 1'b0;
        lb_we   = 1'b0;
        phase   = tile_phase_e'({row_q[0], col_q[0]});

        if (bus.clr_i) begin
            col_d  = '0;
            row_d  = '0;
            hold_d = '0;
        end else if (bus.vld_i) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end

            case (phase)
                PH_TOP_L, PH_BOT_L: hold_d = bus.din;
                PH_TOP_R:           lb_we  = 1'b1;
                PH_BOT_R: begin
                    dout_d  = vmax;
                    vld_o_d = 1'b1;
                    row_o_d = row_q >> 1;
                    col_o_d = col_q >> 1;
                    fd_d    = (row_q == ROW_LAST) && (col_q == COL_LAST);
                end
                default: ;
            endcase
        end
    end

    // Control and output registers, asynchronously cleared.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col_q   <= '0;
            row_q   <= '0;
            hold_q  <= '0;
            dout_q  <= '0;
            row_o_q <= '0;
            col_o_q <= '0;
            vld_o_q <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            hold_q  <= hold_d;
            dout_q  <= dout_d;
            row_o_q <= row_o_d;
            col_o_q <= col_o_d;
            vld_o_q <= vld_o_d;
            fd_q    <= fd_d;
        end
    end

    // Line buffer of top-row horizontal maxima; no reset, every entry is rewritten before use.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            linebuf_q[lb_idx] <= hmax;
        end
    end

    assign bus.vld_o      = vld_o_q;
    assign bus.dout       = dout_q;
    assign bus.row_o      = row_o_q;
    assign bus.col_o      = col_o_q;
    assign bus.frame_done = fd_q;

endmodule
